// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } dsa_state_t;

    // Number of digits processed per operation.
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of the digit index register; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_digit.sv
// Combinational ripple slice: adds one DIGIT-wide chunk plus carry-in and
// exposes both the carry out of the slice and the carry into its top bit.
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] full;

    // Slice sum with carry; the carry into the top bit is recovered from the
    // top bit's own sum equation (s = a ^ b ^ c).
    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
        s     = full[DIGIT-1:0];
        co    = full[DIGIT];
        c_msb = a[DIGIT-1] ^ b[DIGIT-1] ^ full[DIGIT-1];
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands are summed DIGIT bits per
// clock, LSB digit first, through a single shared ripple slice.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int IW   = idx_width(NDIG);

    if ((WIDTH % DIGIT) != 0 || NDIG < 1 || NDIG > 64) begin : g_param_check
        $error("digit_serial_adder: WIDTH must be a multiple of DIGIT with 1 <= WIDTH/DIGIT <= 64");
    end

    dsa_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             ready_raw;

    logic [DIGIT-1:0] slice_a, slice_b, slice_s;
    logic             slice_co, slice_cmsb;

    // Current digit of the latched operands feeds the shared slice.
    always_comb begin
        slice_a = a_q[idx_q*DIGIT +: DIGIT];
        slice_b = b_q[idx_q*DIGIT +: DIGIT];
    end

    rca_digit #(
        .DIGIT(DIGIT)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .ci   (carry_q),
        .s    (slice_s),
        .co   (slice_co),
        .c_msb(slice_cmsb)
    );

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: accept, step one digit per cycle, hold until consumed.
    // Subtraction is folded into the load as a + ~b + !cin.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        ready_raw = 1'b0;

        case (state_q)
            IDLE: begin
                ready_raw = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = cin ^ sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*DIGIT +: DIGIT] = slice_s;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NDIG - 1)) begin
                    cout_d  = slice_co;
                    ovf_d   = slice_cmsb ^ slice_co;
                    idx_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                ready_raw = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        a_d     = a;
                        b_d     = b ^ {WIDTH{sub}};
                        carry_d = cin ^ sub;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = ready_raw & ~rst;
    assign out_valid = (state_q == HOLD);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: several DUT configurations run side by side, each with its
// own driver, ready generator and monitor against an arithmetic reference.
module tb_digit_serial_adder;

    localparam int NCFG  = 4;
    localparam int NRAND = 1500;

    function automatic int cfg_w(input int g);
        case (g)
            0:       return 16;
            1:       return 16;
            2:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic int cfg_d(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 8;
        endcase
    endfunction

    typedef struct {
        longint sum;
        bit     cout;
        bit     ovf;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference: true integer sum/difference, with cout and signed overflow
    // derived from range checks on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input longint va, input longint vb,
                                   input bit vc, input bit vs, input longint acc);
        exp_t   r;
        longint m    = longint'(1) << w;
        longint half = m >> 1;
        longint ci   = vc ? 64'sd1 : 64'sd0;
        longint sa   = (va >= half) ? va - m : va;
        longint sb   = (vb >= half) ? vb - m : vb;
        longint u, s;
        if (!vs) begin
            u      = va + vb + ci;
            s      = sa + sb + ci;
            r.cout = (u >= m);
        end else begin
            u      = va - vb - ci;
            s      = sa - sb - ci;
            r.cout = (u >= 0);
        end
        r.sum = u & (m - 1);
        r.ovf = (s >= half) || (s < -half);
        r.acc = acc;
        return r;
    endfunction

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int W = cfg_w(g);
        localparam int D = cfg_d(g);
        localparam int N = W / D;

        logic         rst       = 1'b1;
        logic         in_valid  = 1'b0;
        logic         in_ready;
        logic [W-1:0] a         = '0;
        logic [W-1:0] b         = '0;
        logic         cin       = 1'b0;
        logic         sub       = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b0;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;

        int     ready_mode = 2;  // 0 random, 1 held low, 2 held high
        longint cyc        = 0;
        exp_t   q[$];
        bit     first_seen = 1'b0;
        bit     fin        = 1'b0;

        digit_serial_adder #(
            .WIDTH(W),
            .DIGIT(D)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .ovf      (ovf)
        );

        always @(posedge clk) cyc <= cyc + 1;

        always @(posedge clk) begin
            #1;
            case (ready_mode)
                0:       out_ready = ($urandom_range(0, 3) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end

        // Monitor: compare presented results, then record any accept.
        always @(negedge clk) begin
            if (rst) begin
                q.delete();
                first_seen = 1'b0;
            end else begin
                if (out_valid) begin
                    check($sformatf("c%0d result expected", g), longint'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        if (!first_seen) begin
                            check($sformatf("c%0d latency", g), cyc - q[0].acc, longint'(N));
                            first_seen = 1'b1;
                        end
                        check($sformatf("c%0d sum", g), longint'(sum), q[0].sum);
                        check($sformatf("c%0d cout", g), longint'(cout), longint'(q[0].cout));
                        check($sformatf("c%0d ovf", g), longint'(ovf), longint'(q[0].ovf));
                        check($sformatf("c%0d in_ready hold", g), longint'(in_ready), longint'(out_ready));
                        if (out_ready) begin
                            q.delete(0);
                            first_seen = 1'b0;
                        end
                    end
                end else begin
                    check($sformatf("c%0d in_ready", g), longint'(in_ready), longint'(q.size() == 0));
                end
                if (in_valid && in_ready)
                    q.push_back(model(W, longint'(a), longint'(b), cin, sub, cyc + 1));
            end
        end

        // Called aligned to posedge+1; returns aligned just after the accepting edge.
        task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vc, input logic vs);
            int t = 0;
            a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
            do begin
                @(negedge clk);
                t++;
            end while (!in_ready && t < 2000);
            check($sformatf("c%0d accept wait", g), longint'(in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
        endtask

        task automatic drain();
            int t = 0;
            while ((q.size() != 0 || out_valid) && t < 5000) begin
                @(posedge clk);
                #1;
                t++;
            end
            check($sformatf("c%0d drain", g), longint'(q.size()), 0);
        endtask

        initial begin
            logic [W-1:0] ones;
            logic [W-1:0] smax;
            logic [W-1:0] smin;
            ones = '1;
            smax = ones >> 1;
            smin = ~smax;

            repeat (3) @(posedge clk);
            #1;
            check($sformatf("c%0d rst in_ready", g), longint'(in_ready), 0);
            check($sformatf("c%0d rst out_valid", g), longint'(out_valid), 0);
            check($sformatf("c%0d rst sum", g), longint'(sum), 0);
            check($sformatf("c%0d rst cout", g), longint'(cout), 0);
            check($sformatf("c%0d rst ovf", g), longint'(ovf), 0);
            rst = 1'b0;
            @(posedge clk);
            #1;

            // Directed vectors, truncated to this configuration's width.
            send(W'(32'h00FF), W'(32'h0001), 1'b0, 1'b0);
            send(W'(32'h7FFF), W'(32'h0001), 1'b0, 1'b0);
            send(W'(32'hFFFF), W'(32'h0001), 1'b1, 1'b0);
            send(W'(32'd5),    W'(32'd3),    1'b0, 1'b1);
            send(W'(32'd3),    W'(32'd5),    1'b0, 1'b1);
            send(W'(32'h8000), W'(32'h0001), 1'b0, 1'b1);
            send(W'(32'h000B), W'(32'h0006), 1'b0, 1'b0);
            send(smax, W'(1), 1'b0, 1'b0);
            send(ones, W'(1), 1'b1, 1'b0);
            send(smin, W'(1), 1'b0, 1'b1);
            send('0, '0, 1'b1, 1'b1);
            drain();

            // Consumer stall with a pending operand, then consume+accept together.
            ready_mode = 1;
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            repeat (N + 12) @(negedge clk);
            check($sformatf("c%0d stall out_valid", g), longint'(out_valid), 1);
            check($sformatf("c%0d stall in_ready", g), longint'(in_ready), 0);
            @(posedge clk);
            #1;
            ready_mode = 2;
            out_ready  = 1'b1;
            @(negedge clk);
            check($sformatf("c%0d swap out_valid", g), longint'(out_valid), 1);
            check($sformatf("c%0d swap in_ready", g), longint'(in_ready), 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            drain();

            // Reset during the second cycle after accept discards the operation.
            send(W'($urandom), W'($urandom), 1'b0, 1'b0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            check($sformatf("c%0d midrst out_valid", g), longint'(out_valid), 0);
            check($sformatf("c%0d midrst sum", g), longint'(sum), 0);
            check($sformatf("c%0d midrst in_ready", g), longint'(in_ready), 0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            send(W'(32'h1234), W'(32'h1111), 1'b0, 1'b0);
            drain();

            // Random traffic with random consumer back-pressure and idle gaps.
            ready_mode = 0;
            for (int i = 0; i < NRAND; i++) begin
                send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            ready_mode = 2;
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        int t = 0;
        while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin) && t < 80000) begin
            @(posedge clk);
            t++;
        end
        check("all configs done",
              longint'(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
